// File: rtl/game_step_scheduler_pkg.sv
// Shared game encodings: master-state codes and the step scheduler state enum.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package game_step_scheduler_pkg;

  // Master state machine encodings as seen on m_state.
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_PLAY = 2'b01,
    MS_WIN  = 2'b10,
    MS_LOSE = 2'b11
  } m_state_t;

  // One game step walks WAIT_TICK -> MOVE -> CHECK [-> TARGET -> SCORE].
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_MOVE,
    ST_CHECK,
    ST_TARGET,
    ST_SCORE,
    ST_OVER
  } sched_state_t;

  function automatic logic is_play(input logic [1:0] ms);
    return ms == MS_PLAY;
  endfunction

endpackage

// File: rtl/game_step_scheduler_if.sv
// Bundle between the step scheduler and the master FSM / snake / target / score blocks.
// Latency: n/a (wiring only).
// Backpressure: req held until ack or timeout on both move and target channels.
interface game_step_scheduler_if #(
  parameter int CNT_W = 25
);
  logic [1:0]       m_state;
  logic             move_req;
  logic             move_ack;
  logic             reached;
  logic             hit_self;
  logic             tgt_req;
  logic             tgt_ack;
  logic             score_inc;
  logic             game_over;
  logic             err;
  logic [CNT_W-1:0] period;

  // Scheduler side.
  modport master (
    input  m_state, move_ack, reached, hit_self, tgt_ack,
    output move_req, tgt_req, score_inc, game_over, err, period
  );

  // Environment side (master FSM, snake, target, score).
  modport slave (
    output m_state, move_ack, reached, hit_self, tgt_ack,
    input  move_req, tgt_req, score_inc, game_over, err, period
  );

endinterface

// File: rtl/game_step_scheduler_handshake.sv
// Request/acknowledge holder with a bounded wait; req follows 'active' from the owning FSM.
// Latency: done/timeout are combinational in the cycle ack is seen / the wait budget ends.
// Backpressure: req is never withdrawn early; it holds until ack or ACK_TIMEOUT cycles elapse.
module step_req_handshake #(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic req,
  output logic done,
  output logic timeout
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;

  assign wait_last = (wait_cnt == WAIT_LAST);
  assign req       = active;
  // An ack outside the request window is ignored.
  assign done      = active && ack;
  // An ack landing on the last allowed cycle still counts as a completion.
  assign timeout   = active && !ack && wait_last;

  // Count cycles spent waiting; restart whenever the request is idle or resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!active || ack || wait_last) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_step_scheduler.sv
// Sequences one snake game step per move tick: move, evaluate, optional retarget and score.
// Latency: first move_req exactly period cycles after entering WAIT_TICK; CHECK and SCORE take 1 cycle each.
// Backpressure: move/target requests hold until ack or ACK_TIMEOUT; a timeout sets sticky err.
module game_step_scheduler #(
  parameter int BASE_PERIOD = 25000000,
  parameter int SPEED_STEP  = 1000000,
  parameter int MIN_PERIOD  = 5000000,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  game_step_scheduler_if.master bus
);
  import game_step_scheduler_pkg::*;

  localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P = CNT_W'(SPEED_STEP);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  // Smallest period from which a full step can be subtracted without dropping below the floor.
  localparam logic [CNT_W:0]   SAT_THRESH = (CNT_W+1)'(MIN_PERIOD + SPEED_STEP);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_sat;
  logic             reached_q, hit_q;
  logic             game_over_q, err_q;
  logic             play, tick_last;
  logic             score_inc_c;
  logic             mv_done, mv_timeout;
  logic             tg_done, tg_timeout;

  assign play       = is_play(bus.m_state);
  assign tick_last  = (tick_cnt_q == period_q - 1'b1);
  // Compare in one extra bit so MIN+STEP near the counter limit cannot wrap.
  assign period_sat = ({1'b0, period_q} >= SAT_THRESH) ? (period_q - STEP_P) : MIN_P;

  step_req_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_move_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_q == ST_MOVE),
    .ack     (bus.move_ack),
    .req     (bus.move_req),
    .done    (mv_done),
    .timeout (mv_timeout)
  );

  step_req_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_tgt_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_q == ST_TARGET),
    .ack     (bus.tgt_ack),
    .req     (bus.tgt_req),
    .done    (tg_done),
    .timeout (tg_timeout)
  );

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded outputs; leaving PLAY mid-handshake waits for the handshake to resolve.
  always_comb begin
    state_d     = state_q;
    score_inc_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (play) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!play)          state_d = ST_IDLE;
        else if (tick_last) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (mv_done)         state_d = play ? ST_CHECK : ST_IDLE;
        else if (mv_timeout) state_d = play ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_CHECK: begin
        if (!play)          state_d = ST_IDLE;
        else if (hit_q)     state_d = ST_OVER;
        else if (reached_q) state_d = ST_TARGET;
        else                state_d = ST_WAIT_TICK;
      end
      ST_TARGET: begin
        if (tg_done)         state_d = play ? ST_SCORE : ST_IDLE;
        else if (tg_timeout) state_d = play ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_SCORE: begin
        score_inc_c = 1'b1;
        state_d     = play ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_OVER: begin
        if (!play) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Move tick divider: runs only while waiting for the next tick, wraps at period-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (state_q == ST_WAIT_TICK && !tick_last) begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end else begin
      tick_cnt_q <= '0;
    end
  end

  // Tick period: restored on a fresh game, shortened with saturation on every score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= BASE_P;
    end else if (state_q == ST_IDLE && play) begin
      period_q <= BASE_P;
    end else if (state_q == ST_SCORE) begin
      period_q <= period_sat;
    end
  end

  // Capture the snake's verdict together with its move acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reached_q <= 1'b0;
      hit_q     <= 1'b0;
    end else if (mv_done) begin
      reached_q <= bus.reached;
      hit_q     <= bus.hit_self;
    end
  end

  // Sticky flags: game_over lives until the next game starts, err until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_over_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && play) game_over_q <= 1'b0;
      else if (state_d == ST_OVER)    game_over_q <= 1'b1;
      if (mv_timeout || tg_timeout)   err_q <= 1'b1;
    end
  end

  assign bus.score_inc = score_inc_c;
  assign bus.game_over = game_over_q;
  assign bus.err       = err_q;
  assign bus.period    = period_q;

endmodule

// File: doc/game_step_scheduler.md
Name: game_step_scheduler

Overview:
- Sequences one game step of the snake game per movement tick.
- Generates a programmable move tick and issues a move request to the snake datapath, then evaluates the result.
- On a target hit it requests a new target position and pulses the score counter.
- Sits between the master state machine and the snake, target and score blocks; tick period shortens as score rises.

Parameters:
- BASE_PERIOD, 25000000, initial tick period in CLK cycles.
- SPEED_STEP, 1000000, period decrement applied per target reached.
- MIN_PERIOD, 5000000, floor for tick period.
- ACK_TIMEOUT, 1024, max cycles to wait for any ACK.
- CNT_W, 25, width of period/tick counters (must hold BASE_PERIOD).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- M_STATE  in  2  master state; 2'b01 = PLAY, others = not playing.
- MOVE_REQ  out  1  request snake to advance one cell.
- MOVE_ACK  in  1  snake move complete; REACHED and HIT_SELF valid in same cycle.
- REACHED  in  1  head on target (sampled with MOVE_ACK).
- HIT_SELF  in  1  head collided with body/wall (sampled with MOVE_ACK).
- TGT_REQ  out  1  request new target position.
- TGT_ACK  in  1  new target latched by generator.
- SCORE_INC  out  1  one-cycle score increment pulse.
- GAME_OVER  out  1  sticky collision flag.
- ERR  out  1  sticky handshake-timeout flag.
- PERIOD  out  CNT_W  current tick period.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE; all outputs 0, except PERIOD=BASE_PERIOD.
  - Tick counter 0; latched REACHED/HIT flags 0.
- States: IDLE, WAIT_TICK, MOVE, CHECK, TARGET, SCORE, OVER.
- IDLE:
  - On M_STATE==PLAY -> WAIT_TICK, tick counter cleared.
  - PERIOD is reset to BASE_PERIOD and GAME_OVER cleared on entry to PLAY from IDLE.
- WAIT_TICK:
  - Counter increments each cycle.
  - When counter==PERIOD-1: counter<=0 and go to MOVE.
  - First MOVE_REQ is asserted exactly PERIOD cycles after entering WAIT_TICK.
- MOVE:
  - MOVE_REQ=1 held until MOVE_ACK sampled high.
  - In that same cycle, latch REACHED/HIT_SELF, drop MOVE_REQ next cycle, go to CHECK.
- CHECK (1 cycle):
  - HIT_SELF latched -> OVER. HIT has priority over REACHED when both are set.
  - Else REACHED latched -> TARGET.
  - Else -> WAIT_TICK.
- TARGET:
  - TGT_REQ=1 until TGT_ACK sampled high, then go to SCORE.
- SCORE (1 cycle):
  - SCORE_INC=1.
  - PERIOD <= max(PERIOD-SPEED_STEP, MIN_PERIOD), with saturating subtract and no underflow wrap.
  - Then -> WAIT_TICK.
- OVER:
  - GAME_OVER=1; no further requests issued.
  - Stays until M_STATE!=PLAY -> IDLE.
- ACK timeout:
  - In MOVE/TARGET a wait counter runs.
  - On reaching ACK_TIMEOUT: drop REQ, set ERR=1 (sticky until reset), go to WAIT_TICK. No SCORE_INC on a timed-out target request.
- Leaving PLAY (M_STATE!=PLAY):
  - From WAIT_TICK/CHECK/SCORE: -> IDLE next cycle. SCORE_INC still fires if already in SCORE.
  - From MOVE/TARGET: REQ is never withdrawn before ACK or timeout; the handshake completes, then -> IDLE, skipping remaining sequence steps.
- ACK arriving while corresponding REQ is low is ignored.
- At most one REQ is high at any time.
- Tick counter does not run outside WAIT_TICK.

Decomposition:
- Shared game package holds:
  - M_STATE encodings (IDLE/PLAY/WIN/LOSE).
  - The scheduler state enum.
- Sub-module: step_req_handshake holds REQ/ACK with timeout counter; instantiated twice (move, target).
- Tick divider and period-saturation logic stay inline.

Test Plan (BASE_PERIOD=10, SPEED_STEP=3, MIN_PERIOD=4, ACK_TIMEOUT=8):
- Reset release, M_STATE=01, MOVE_ACK returned 2 cycles after REQ with REACHED=0 -> MOVE_REQ rises 10 cycles after PLAY entry; repeats every 10 + handshake cycles; SCORE_INC never pulses; PERIOD stays 10.
- REACHED=1 on three consecutive moves, TGT_ACK after 1 cycle -> TGT_REQ each step; SCORE_INC single pulse each step; PERIOD 10->7->4->4 (saturation).
- HIT_SELF=1 and REACHED=1 same ACK -> GAME_OVER=1, no TGT_REQ, no SCORE_INC; no MOVE_REQ for 50 cycles; M_STATE=00 then 01 -> GAME_OVER=0, PERIOD=10.
- MOVE_ACK never asserted -> MOVE_REQ drops after 8 cycles, ERR=1 and stays 1; next MOVE_REQ after a further 10 tick cycles.
- M_STATE->00 during MOVE with REQ high -> REQ held until ACK, then IDLE; no TGT_REQ even if REACHED=1.
- RESET=0 asserted mid-TARGET -> TGT_REQ, SCORE_INC, ERR drop immediately (async); PERIOD=10.
